// File: rtl/xy_dac_pkg.sv
// xy_dac_pkg: shared definitions for the XY DAC list player.
//   - state_e        : playback FSM states
//   - BLANK_BIT      : position of the beam-blank flag in word0 of a point
//   - WORD_PER_POINT : SRAM words per XY point (word0 = blank/x, word1 = y)
//   - midscale()     : DAC code for the centre of the screen
package xy_dac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_HOLD,
    ST_DRAIN
  } state_e;

  localparam int unsigned BLANK_BIT      = 15;
  localparam int unsigned WORD_PER_POINT = 2;

  // Midscale code 2^(bits-1); DAC widths are limited to 15 bits.
  function automatic logic [14:0] midscale(input int unsigned bits);
    return 15'(1) << (bits - 1);
  endfunction

endpackage

// File: rtl/xy_dac_tick.sv
// xy_dac_tick: sample-rate divider.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : force the count back to 0
//   enable       : count while high; held at 0 otherwise
//   tick         : high for one cycle when the count reaches SAMPLE_DIV-1
module xy_dac_tick #(
  parameter int unsigned SAMPLE_DIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && !clear && (cnt_q == CNT_MAX);

endmodule

// File: rtl/xy_dac_player.sv
// xy_dac_player: replays a list of XY points from SRAM to an XY DAC.
//   Control : start / stop / loop, base_addr, point_count; busy, done,
//             underrun_cnt (saturating missed-sample count).
//   SRAM    : rd_req_valid/rd_req_ready/rd_addr request handshake,
//             rd_data_valid/rd_data single-cycle return; one read in flight.
//   DAC     : dac_x, dac_y, dac_blank registered, dac_strobe one-cycle pulse
//             per new sample, issued every SAMPLE_DIV clocks.
// Each point is two words (blank/x, then y). One point is prefetched into a
// buffer; a sample tick moves the buffer to the DAC registers.
module xy_dac_player
  import xy_dac_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_BITS = 20,
  parameter int unsigned SRAM_DATA_BITS = 16,
  parameter int unsigned DAC_DATA_BITS  = 10,
  parameter int unsigned SAMPLE_DIV     = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop,
  input  logic [SRAM_ADDR_BITS-1:0] base_addr,
  input  logic [SRAM_ADDR_BITS-2:0] point_count,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                underrun_cnt,
  output logic                      rd_req_valid,
  input  logic                      rd_req_ready,
  output logic [SRAM_ADDR_BITS-1:0] rd_addr,
  input  logic                      rd_data_valid,
  input  logic [SRAM_DATA_BITS-1:0] rd_data,
  output logic [DAC_DATA_BITS-1:0]  dac_x,
  output logic [DAC_DATA_BITS-1:0]  dac_y,
  output logic                      dac_blank,
  output logic                      dac_strobe
);

  localparam int unsigned CNT_W = SRAM_ADDR_BITS - 1;
  localparam logic [DAC_DATA_BITS-1:0] MIDSCALE = DAC_DATA_BITS'(midscale(DAC_DATA_BITS));

  state_e                    state_q, state_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      loop_q, loop_d;
  logic [SRAM_ADDR_BITS-1:0] base_q, base_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [CNT_W-1:0]          idx_q, idx_d;
  logic [SRAM_ADDR_BITS-1:0] ptr_q, ptr_d;
  logic                      buf_valid_q, buf_valid_d;
  logic [DAC_DATA_BITS-1:0]  buf_x_q, buf_x_d;
  logic [DAC_DATA_BITS-1:0]  buf_y_q, buf_y_d;
  logic                      buf_blank_q, buf_blank_d;
  logic [DAC_DATA_BITS-1:0]  dac_x_q, dac_x_d;
  logic [DAC_DATA_BITS-1:0]  dac_y_q, dac_y_d;
  logic                      dac_blank_q, dac_blank_d;
  logic                      dac_strobe_q, dac_strobe_d;
  logic [7:0]                underrun_q, underrun_d;
  logic                      rd_req_valid_q, rd_req_valid_d;
  logic [SRAM_ADDR_BITS-1:0] rd_addr_q, rd_addr_d;

  logic tick;
  logic tick_clear;
  logic stop_now;
  logic last_point;
  logic rsvd_unused;

  xy_dac_tick #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (tick_clear),
    .enable (busy_q),
    .tick   (tick)
  );

  assign stop_now    = busy_q && stop;
  assign last_point  = (idx_q == count_q - CNT_W'(1));
  assign rsvd_unused = &{1'b0, rd_data};

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    loop_d       = loop_q;
    base_d       = base_q;
    count_d      = count_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    buf_valid_d  = buf_valid_q;
    buf_x_d      = buf_x_q;
    buf_y_d      = buf_y_q;
    buf_blank_d  = buf_blank_q;
    dac_x_d      = dac_x_q;
    dac_y_d      = dac_y_q;
    dac_blank_d  = dac_blank_q;
    dac_strobe_d = 1'b0;
    underrun_d   = underrun_q;
    tick_clear   = 1'b0;

    // Sample emission; a stop in the same cycle suppresses it.
    if (busy_q && tick && !stop) begin
      if (buf_valid_q) begin
        dac_x_d      = buf_x_q;
        dac_y_d      = buf_y_q;
        dac_blank_d  = buf_blank_q;
        dac_strobe_d = 1'b1;
        buf_valid_d  = 1'b0;
      end else if (underrun_q != 8'hFF) begin
        underrun_d = underrun_q + 8'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          loop_d     = loop;
          base_d     = base_addr;
          count_d    = point_count;
          underrun_d = '0;
          tick_clear = 1'b1;
          if (point_count == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            idx_d   = '0;
            ptr_d   = base_addr;
            state_d = ST_REQ0;
          end
        end
      end
      // A presented request must complete its handshake even when aborted
      // (busy already low), after which its data is drained.
      ST_REQ0: begin
        if (rd_req_ready) begin
          state_d = (busy_q && !stop) ? ST_WAIT0 : ST_DRAIN;
        end
      end
      ST_REQ1: begin
        if (rd_req_ready) begin
          state_d = (busy_q && !stop) ? ST_WAIT1 : ST_DRAIN;
        end
      end
      ST_WAIT0: begin
        if (rd_data_valid) begin
          buf_blank_d = rd_data[BLANK_BIT];
          buf_x_d     = rd_data[DAC_DATA_BITS-1:0];
          state_d     = stop_now ? ST_IDLE : ST_REQ1;
        end else if (stop_now) begin
          state_d = ST_DRAIN;
        end
      end
      ST_WAIT1: begin
        if (rd_data_valid) begin
          buf_y_d = rd_data[DAC_DATA_BITS-1:0];
          if (stop_now) begin
            state_d = ST_IDLE;
          end else begin
            buf_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end else if (stop_now) begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (stop_now) begin
          state_d = ST_IDLE;
        end else if (!buf_valid_q) begin
          if (last_point) begin
            if (loop_q) begin
              idx_d   = '0;
              ptr_d   = base_q;
              state_d = ST_REQ0;
            end else begin
              done_d      = 1'b1;
              busy_d      = 1'b0;
              dac_blank_d = 1'b1;
              state_d     = ST_IDLE;
            end
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            ptr_d   = ptr_q + SRAM_ADDR_BITS'(WORD_PER_POINT);
            state_d = ST_REQ0;
          end
        end
      end
      ST_DRAIN: begin
        if (rd_data_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (stop_now) begin
      busy_d      = 1'b0;
      dac_blank_d = 1'b1;
      buf_valid_d = 1'b0;
    end

    rd_req_valid_d = (state_d == ST_REQ0) || (state_d == ST_REQ1);
    rd_addr_d      = (state_d == ST_REQ1) ? ptr_d + SRAM_ADDR_BITS'(1) : ptr_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      loop_q         <= 1'b0;
      base_q         <= '0;
      count_q        <= '0;
      idx_q          <= '0;
      ptr_q          <= '0;
      buf_valid_q    <= 1'b0;
      buf_x_q        <= '0;
      buf_y_q        <= '0;
      buf_blank_q    <= 1'b0;
      dac_x_q        <= MIDSCALE;
      dac_y_q        <= MIDSCALE;
      dac_blank_q    <= 1'b1;
      dac_strobe_q   <= 1'b0;
      underrun_q     <= '0;
      rd_req_valid_q <= 1'b0;
      rd_addr_q      <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      loop_q         <= loop_d;
      base_q         <= base_d;
      count_q        <= count_d;
      idx_q          <= idx_d;
      ptr_q          <= ptr_d;
      buf_valid_q    <= buf_valid_d;
      buf_x_q        <= buf_x_d;
      buf_y_q        <= buf_y_d;
      buf_blank_q    <= buf_blank_d;
      dac_x_q        <= dac_x_d;
      dac_y_q        <= dac_y_d;
      dac_blank_q    <= dac_blank_d;
      dac_strobe_q   <= dac_strobe_d;
      underrun_q     <= underrun_d;
      rd_req_valid_q <= rd_req_valid_d;
      rd_addr_q      <= rd_addr_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign underrun_cnt = underrun_q;
  assign rd_req_valid = rd_req_valid_q;
  assign rd_addr      = rd_addr_q;
  assign dac_x        = dac_x_q;
  assign dac_y        = dac_y_q;
  assign dac_blank    = dac_blank_q;
  assign dac_strobe   = dac_strobe_q;

endmodule

// File: tb/tb_xy_dac_player.sv
// tb_xy_dac_player: directed bench for xy_dac_player with a simple SRAM
// model of configurable latency (data returned for one cycle, lat cycles
// after the accepting edge). SAMPLE_DIV is 10 so a 2-cycle SRAM keeps up.
module tb_xy_dac_player;

  localparam int unsigned DIV = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic        loop;
  logic [19:0] base_addr;
  logic [18:0] point_count;
  logic        busy;
  logic        done;
  logic [7:0]  underrun_cnt;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [19:0] rd_addr;
  logic        rd_data_valid = 1'b0;
  logic [15:0] rd_data = '0;
  logic [9:0]  dac_x;
  logic [9:0]  dac_y;
  logic        dac_blank;
  logic        dac_strobe;

  xy_dac_player #(
    .SRAM_ADDR_BITS(20),
    .SRAM_DATA_BITS(16),
    .DAC_DATA_BITS (10),
    .SAMPLE_DIV    (DIV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .loop         (loop),
    .base_addr    (base_addr),
    .point_count  (point_count),
    .busy         (busy),
    .done         (done),
    .underrun_cnt (underrun_cnt),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr      (rd_addr),
    .rd_data_valid(rd_data_valid),
    .rd_data      (rd_data),
    .dac_x        (dac_x),
    .dac_y        (dac_y),
    .dac_blank    (dac_blank),
    .dac_strobe   (dac_strobe)
  );

  always #5 clk = ~clk;

  // SRAM model and event counters
  logic [15:0] mem [bit [19:0]];
  int unsigned lat = 2;
  int unsigned pend = 0;
  logic [15:0] pend_data = '0;
  logic [19:0] addr_log [$];
  int cyc = 0;
  int done_cnt = 0;
  int strobe_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (dac_strobe) strobe_cnt <= strobe_cnt + 1;
    rd_data_valid <= 1'b0;
    if (pend != 0) begin
      if (pend == 1) begin
        rd_data_valid <= 1'b1;
        rd_data       <= pend_data;
      end
      pend <= pend - 1;
    end
    if (reset_n && rd_req_valid && rd_req_ready) begin
      pend      <= lat;
      pend_data <= mem.exists(rd_addr) ? mem[rd_addr] : 16'hDEAD;
      addr_log.push_back(rd_addr);
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [19:0] b, input logic [18:0] n, input logic l,
                          output int e0);
    base_addr   = b;
    point_count = n;
    loop        = l;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0    = cyc;
  endtask

  task automatic wait_strobe(input int max, output int t, output logic ok);
    ok = 1'b0;
    t  = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (dac_strobe) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  // Check the next strobe: arrival cycle relative to e0 and the sample.
  task automatic expect_sample(input string tag, input int e0, input int rel,
                               input logic [9:0] x, input logic [9:0] y, input logic b);
    int   t;
    logic ok;
    wait_strobe(60, t, ok);
    check({tag, "_seen"}, 32'(ok), 32'd1);
    check({tag, "_time"}, 32'(t - e0), 32'(rel));
    check({tag, "_x"}, 32'(dac_x), 32'(x));
    check({tag, "_y"}, 32'(dac_y), 32'(y));
    check({tag, "_blank"}, 32'(dac_blank), 32'(b));
  endtask

  task automatic check_addrs(input string tag, input logic [19:0] first, input int n);
    logic [19:0] a;
    check({tag, "_nreads"}, 32'(addr_log.size()), 32'(n));
    a = first;
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, (i < addr_log.size()) ? 32'(addr_log[i]) : 32'hFFFF_FFFF, 32'(a));
      a = a + 20'd1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   e0;
    int   t;
    int   n0;
    int   d0;
    int   s0;
    logic ok;

    reset_n      = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    loop         = 1'b0;
    base_addr    = '0;
    point_count  = '0;
    rd_req_ready = 1'b1;

    mem[20'h00100] = 16'h7C10;  mem[20'h00101] = 16'h0020;  // reserved bits set
    mem[20'h00102] = 16'h83FF;  mem[20'h00103] = 16'h0000;
    mem[20'h00104] = 16'h0200;  mem[20'h00105] = 16'hFD00;  // word1 bit15 ignored
    mem[20'h00200] = 16'h0155;  mem[20'h00201] = 16'h02AA;  // A
    mem[20'h00202] = 16'h80AB;  mem[20'h00203] = 16'h0354;  // B
    mem[20'h00300] = 16'h0123;  mem[20'h00301] = 16'h0321;
    mem[20'h00302] = 16'h8001;  mem[20'h00303] = 16'h03FE;
    mem[20'hFFFFE] = 16'h0111;  mem[20'hFFFFF] = 16'h0222;
    mem[20'h00000] = 16'h8333;  mem[20'h00001] = 16'h0044;

    repeat (3) @(negedge clk);
    check("rst_dac_x", 32'(dac_x), 32'd512);
    check("rst_dac_y", 32'(dac_y), 32'd512);
    check("rst_blank", 32'(dac_blank), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(rd_req_valid), 32'd0);
    check("rst_underrun", 32'(underrun_cnt), 32'd0);
    check("rst_strobe", 32'(dac_strobe), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Three points, no loop
    addr_log.delete();
    do_start(20'h00100, 19'd3, 1'b0, e0);
    check("t1_busy", 32'(busy), 32'd1);
    expect_sample("t1_p0", e0, DIV,     10'h010, 10'h020, 1'b0);
    expect_sample("t1_p1", e0, 2 * DIV, 10'h3FF, 10'h000, 1'b1);
    expect_sample("t1_p2", e0, 3 * DIV, 10'h200, 10'h100, 1'b0);
    @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_blank_end", 32'(dac_blank), 32'd1);
    check("t1_x_hold", 32'(dac_x), 32'h200);
    check("t1_y_hold", 32'(dac_y), 32'h100);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_underrun", 32'(underrun_cnt), 32'd0);
    check_addrs("t1", 20'h00100, 6);

    // Loop of A,B, then stop while the y word of B is in flight
    addr_log.delete();
    d0 = done_cnt;
    do_start(20'h00200, 19'd2, 1'b1, e0);
    expect_sample("t2_a0", e0, DIV,     10'h155, 10'h2AA, 1'b0);
    expect_sample("t2_b0", e0, 2 * DIV, 10'h0AB, 10'h354, 1'b1);
    expect_sample("t2_a1", e0, 3 * DIV, 10'h155, 10'h2AA, 1'b0);
    expect_sample("t2_b1", e0, 4 * DIV, 10'h0AB, 10'h354, 1'b1);
    expect_sample("t2_a2", e0, 5 * DIV, 10'h155, 10'h2AA, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_req_valid && rd_addr == 20'h00203) begin
        ok = 1'b1;
        break;
      end
    end
    check("t2_req1_seen", 32'(ok), 32'd1);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t2_stop_busy", 32'(busy), 32'd0);
    check("t2_stop_blank", 32'(dac_blank), 32'd1);
    n0 = addr_log.size();
    s0 = strobe_cnt;
    repeat (25) @(negedge clk);
    check("t2_no_done", 32'(done_cnt - d0), 32'd0);
    check("t2_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check("t2_no_reads", 32'(addr_log.size() - n0), 32'd0);
    check("t2_x_hold", 32'(dac_x), 32'h155);
    check("t2_req_idle", 32'(rd_req_valid), 32'd0);

    // Slow SRAM: missed ticks counted, outputs held between strobes
    lat = 10;
    addr_log.delete();
    do_start(20'h00300, 19'd2, 1'b0, e0);
    expect_sample("t3_p0", e0, 3 * DIV, 10'h123, 10'h321, 1'b0);
    check("t3_underrun_a", 32'(underrun_cnt), 32'd2);
    repeat (15) @(negedge clk);
    check("t3_x_held", 32'(dac_x), 32'h123);
    check("t3_y_held", 32'(dac_y), 32'h321);
    check("t3_no_strobe", 32'(dac_strobe), 32'd0);
    expect_sample("t3_p1", e0, 6 * DIV, 10'h001, 10'h3FE, 1'b1);
    check("t3_underrun_b", 32'(underrun_cnt), 32'd4);
    @(negedge clk);
    check("t3_done", 32'(done), 32'd1);

    // Address wrap past the top of SRAM; underrun cleared by start
    lat = 2;
    addr_log.delete();
    @(negedge clk);
    do_start(20'hFFFFE, 19'd2, 1'b0, e0);
    check("t4_underrun_clr", 32'(underrun_cnt), 32'd0);
    expect_sample("t4_p0", e0, DIV,     10'h111, 10'h222, 1'b0);
    expect_sample("t4_p1", e0, 2 * DIV, 10'h333, 10'h044, 1'b1);
    @(negedge clk);
    check("t4_done", 32'(done), 32'd1);
    check("t4_nreads", 32'(addr_log.size()), 32'd4);
    check("t4_addr0", (addr_log.size() > 0) ? 32'(addr_log[0]) : 32'hFFFF_FFFF, 32'hFFFFE);
    check("t4_addr1", (addr_log.size() > 1) ? 32'(addr_log[1]) : 32'hFFFF_FFFF, 32'hFFFFF);
    check("t4_addr2", (addr_log.size() > 2) ? 32'(addr_log[2]) : 32'hFFFF_FFFF, 32'h00000);
    check("t4_addr3", (addr_log.size() > 3) ? 32'(addr_log[3]) : 32'hFFFF_FFFF, 32'h00001);

    // point_count = 0: immediate done, no reads
    addr_log.delete();
    @(negedge clk);
    do_start(20'h00400, 19'd0, 1'b0, e0);
    check("t5_done", 32'(done), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t5_done_pulse", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    check("t5_busy_stay", 32'(busy), 32'd0);
    check("t5_no_reads", 32'(addr_log.size()), 32'd0);

    // start and stop together: stop wins
    d0 = done_cnt;
    stop = 1'b1;
    do_start(20'h00200, 19'd2, 1'b0, e0);
    stop = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("t6_no_reads", 32'(addr_log.size()), 32'd0);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
